// File: rtl/busca_instrucao.sv
`default_nettype none
// ============================================================================
//  Module   : busca_instrucao
//  Purpose  : Instruction fetch/decode stage in front of the control unit.
//             Holds the program counter, fetches 8-bit instructions over a
//             request/valid handshake, splits them into opcode/operando and
//             hands them on with a ready/stall handshake. JMP and HALT are
//             executed here and never reach the control unit.
//  Ports    : clock, reset_n (async, active low)
//             enable                 - run permission (IDLE / ISSUE)
//             instrAddr, instrRd     - program-memory request
//             instrData, instrValid  - program-memory response
//             opcode, operando       - decoded instruction (registered)
//             instrReady, stall      - handshake towards the control unit
//             pc, halted             - program counter, sticky halt flag
//  Revision : 1.0 - initial release
// ============================================================================
module busca_instrucao #(
   parameter int                ADDR_W   = 8,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              enable,
   output logic [ADDR_W-1:0] instrAddr,
   output logic              instrRd,
   input  logic [7:0]        instrData,
   input  logic              instrValid,
   output logic [3:0]        opcode,
   output logic [3:0]        operando,
   output logic              instrReady,
   input  logic              stall,
   output logic [ADDR_W-1:0] pc,
   output logic              halted
);

   localparam logic [3:0] c_OP_HALT = 4'b1111;
   localparam logic [3:0] c_OP_JMP  = 4'b1110;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_ISSUE  = 3'd3,
      S_HALTED = 3'd4
   } state_t;

   state_t            r_state;
   logic [7:0]        r_ir;
   logic [ADDR_W-1:0] r_pc;
   logic [3:0]        r_opcode;
   logic [3:0]        r_operando;
   logic              r_halted;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state    <= S_IDLE;
         r_ir       <= 8'h00;
         r_pc       <= RESET_PC;
         r_opcode   <= 4'h0;
         r_operando <= 4'h0;
         r_halted   <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (enable) r_state <= S_FETCH;
            end
            S_FETCH: begin
               // Request stays up through any number of wait states.
               if (instrValid) begin
                  r_ir    <= instrData;
                  r_state <= S_DECODE;
               end
            end
            S_DECODE: begin
               r_opcode   <= r_ir[7:4];
               r_operando <= r_ir[3:0];
               if (r_ir[7:4] == c_OP_HALT) begin
                  r_halted <= 1'b1;
                  r_state  <= S_HALTED;
               end else if (r_ir[7:4] == c_OP_JMP) begin
                  r_pc    <= ADDR_W'(r_ir[3:0]);
                  r_state <= enable ? S_FETCH : S_IDLE;
               end else begin
                  // pc already points past the instruction while it is issued.
                  r_pc    <= r_pc + ADDR_W'(1);
                  r_state <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               if (!stall) r_state <= enable ? S_FETCH : S_IDLE;
            end
            S_HALTED: begin
               r_state <= S_HALTED;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   // Handshake outputs are pure state decodes, so reset clears them at once.
   assign instrRd    = (r_state == S_FETCH);
   assign instrReady = (r_state == S_ISSUE);
   assign instrAddr  = r_pc;
   assign pc         = r_pc;
   assign opcode     = r_opcode;
   assign operando   = r_operando;
   assign halted     = r_halted;

endmodule
`default_nettype wire

// File: tb/tb_busca_instrucao.sv
`default_nettype none
// ============================================================================
//  Module   : tb_busca_instrucao
//  Purpose  : Self-checking bench for busca_instrucao. A program-level model
//             executes the memory image and produces the expected fetch
//             addresses and forwarded instructions; a per-cycle process acts
//             as memory / control unit and compares against that model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_busca_instrucao;

   logic       clock = 1'b0;
   logic       reset_n;
   logic       enable;
   logic [7:0] instrAddr;
   logic       instrRd;
   logic [7:0] instrData;
   logic       instrValid;
   logic [3:0] opcode;
   logic [3:0] operando;
   logic       instrReady;
   logic       stall;
   logic [7:0] pc;
   logic       halted;

   busca_instrucao #(.ADDR_W(8), .RESET_PC(8'h00)) dut (
      .clock      (clock),
      .reset_n    (reset_n),
      .enable     (enable),
      .instrAddr  (instrAddr),
      .instrRd    (instrRd),
      .instrData  (instrData),
      .instrValid (instrValid),
      .opcode     (opcode),
      .operando   (operando),
      .instrReady (instrReady),
      .stall      (stall),
      .pc         (pc),
      .halted     (halted)
   );

   always #5 clock = ~clock;

   typedef struct packed {
      logic [3:0] op;
      logic [3:0] opr;
      logic [7:0] pcn;
   } iss_t;

   logic [7:0] mem [256];
   logic [7:0] fetch_q [$];
   iss_t       issue_q [$];
   int         rd_len [$];
   int         ready_len [$];
   int         xfer_cyc [$];
   logic [7:0] obs [$];
   logic [7:0] obs_addr [$];

   int   tests = 0;
   int   fails = 0;
   int   cyc   = 0;
   int   wait_cfg = 0;
   int   stall_cfg = 0;
   int   fcnt = 0;
   int   icnt = 0;
   int   rd_run = 0;
   int   rdy_run = 0;
   int   en_cyc = 0;
   logic model_on = 1'b0;
   logic force_valid = 1'b0;

   always @(posedge clock) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Program-level model: walk the image from start, recording every fetch
   // address and every instruction that must reach the control unit.
   task automatic run_model(input logic [7:0] start, input int limit);
      logic [7:0] p;
      logic [7:0] ir;
      p = start;
      fetch_q.delete();
      issue_q.delete();
      for (int n = 0; n < limit; n++) begin
         fetch_q.push_back(p);
         ir = mem[p];
         if (ir[7:4] == 4'hF) break;
         if (ir[7:4] == 4'hE) begin
            p = {4'h0, ir[3:0]};
         end else begin
            p = p + 8'd1;
            issue_q.push_back('{op: ir[7:4], opr: ir[3:0], pcn: p});
         end
      end
   endtask

   // Memory + control-unit responder and per-cycle compare against the model.
   always @(negedge clock) begin
      if (model_on && reset_n) begin
         if (instrRd) begin
            rd_run++;
            if (fetch_q.size() > 0) check("fetch_addr", 32'(instrAddr), 32'(fetch_q[0]));
            check("ready_in_fetch", 32'(instrReady), 32'd0);
         end
         if (instrReady) begin
            rdy_run++;
            if (issue_q.size() == 0) begin
               check("spurious_ready", 32'(instrReady), 32'd0);
            end else begin
               check("opcode", 32'(opcode), 32'(issue_q[0].op));
               check("operando", 32'(operando), 32'(issue_q[0].opr));
            end
         end
         fcnt = instrRd ? fcnt + 1 : 0;
         instrValid = instrRd && (fetch_q.size() > 0) && (fcnt > wait_cfg);
         instrData  = mem[instrAddr];
         if (instrValid) begin
            obs_addr.push_back(fetch_q.pop_front());
            rd_len.push_back(rd_run);
            rd_run = 0;
            fcnt   = 0;
         end
         icnt  = instrReady ? icnt + 1 : 0;
         stall = instrReady && (icnt <= stall_cfg);
         if (instrReady && !stall && issue_q.size() > 0) begin
            check("pc_at_issue", 32'(pc), 32'(issue_q[0].pcn));
            void'(issue_q.pop_front());
            obs.push_back({opcode, operando});
            ready_len.push_back(rdy_run);
            xfer_cyc.push_back(cyc);
            rdy_run = 0;
            icnt    = 0;
         end
      end else begin
         instrValid = force_valid;
         instrData  = 8'hE3;
         stall      = 1'b0;
         fcnt = 0; icnt = 0; rd_run = 0; rdy_run = 0;
      end
   end

   task automatic do_reset();
      model_on = 1'b0;
      force_valid = 1'b0;
      enable = 1'b0;
      reset_n = 1'b0;
      repeat (2) @(negedge clock);
      reset_n = 1'b1;
      for (int i = 0; i < 256; i++) mem[i] = 8'hF0;
      wait_cfg = 0; stall_cfg = 0;
      rd_len.delete(); ready_len.delete(); xfer_cyc.delete();
      obs.delete(); obs_addr.delete();
   endtask

   task automatic wait_drain(input int budget);
      int n;
      n = 0;
      while ((fetch_q.size() > 0 || issue_q.size() > 0) && n < budget) begin
         @(negedge clock);
         n++;
      end
      check("drain_timeout", 32'(n < budget), 32'd1);
   endtask

   initial begin
      reset_n = 1'b0;
      enable  = 1'b0;

      // ---------------- reset values ----------------
      repeat (2) @(negedge clock);
      check("rst_pc", 32'(pc), 32'h00);
      check("rst_addr", 32'(instrAddr), 32'h00);
      check("rst_rd", 32'(instrRd), 32'd0);
      check("rst_ready", 32'(instrReady), 32'd0);
      check("rst_halted", 32'(halted), 32'd0);
      check("rst_opcode", 32'(opcode), 32'd0);
      check("rst_operando", 32'(operando), 32'd0);
      do_reset();
      for (int i = 0; i < 10; i++) begin
         @(negedge clock);
         check("idle_rd", 32'(instrRd), 32'd0);
      end
      check("idle_pc", 32'(pc), 32'h00);

      // ---------------- straight line + HALT ----------------
      do_reset();
      mem[0] = 8'hC3; mem[1] = 8'hD5; mem[2] = 8'hF0;
      run_model(8'h00, 16);
      model_on = 1'b1;
      en_cyc = cyc;
      enable = 1'b1;
      wait_drain(100);
      repeat (3) @(negedge clock);
      check("sl_count", 32'(obs.size()), 32'd2);
      check("sl_first", 32'(obs[0]), 32'hC3);
      check("sl_second", 32'(obs[1]), 32'hD5);
      check("sl_latency", 32'(xfer_cyc[0] - en_cyc), 32'd3);
      check("sl_spacing", 32'(xfer_cyc[1] - xfer_cyc[0]), 32'd3);
      check("halt_flag", 32'(halted), 32'd1);
      check("halt_pc", 32'(pc), 32'h02);
      check("halt_opcode", 32'(opcode), 32'hF);
      check("halt_operando", 32'(operando), 32'h0);
      model_on = 1'b0;
      force_valid = 1'b1;
      for (int i = 0; i < 6; i++) begin
         enable = i[0];
         @(negedge clock);
         check("halt_rd", 32'(instrRd), 32'd0);
         check("halt_ready", 32'(instrReady), 32'd0);
         check("halt_sticky", 32'(halted), 32'd1);
      end
      check("halt_pc_hold", 32'(pc), 32'h02);

      // ---------------- wait states and stall ----------------
      do_reset();
      mem[0] = 8'h47; mem[1] = 8'hF0;
      wait_cfg = 3; stall_cfg = 4;
      run_model(8'h00, 16);
      model_on = 1'b1;
      enable = 1'b1;
      wait_drain(100);
      repeat (3) @(negedge clock);
      check("ws_rd_len", 32'(rd_len[0]), 32'd4);
      check("ws_ready_len", 32'(ready_len[0]), 32'd5);
      check("ws_value", 32'(obs[0]), 32'h47);
      check("ws_halted", 32'(halted), 32'd1);

      // ---------------- JMP ----------------
      do_reset();
      mem[0] = 8'hE7; mem[7] = 8'h35; mem[8] = 8'hF0;
      run_model(8'h00, 16);
      model_on = 1'b1;
      enable = 1'b1;
      wait_drain(100);
      repeat (3) @(negedge clock);
      check("jmp_target", 32'(obs_addr[1]), 32'h07);
      check("jmp_issued", 32'(obs.size()), 32'd1);
      check("jmp_value", 32'(obs[0]), 32'h35);
      check("jmp_pc", 32'(pc), 32'h08);

      // ---------------- pc wrap ----------------
      do_reset();
      for (int i = 0; i < 256; i++) mem[i] = 8'h2A;
      run_model(8'h00, 256);
      model_on = 1'b1;
      enable = 1'b1;
      wait_drain(2000);
      repeat (2) @(negedge clock);
      check("wrap_count", 32'(obs.size()), 32'd256);
      check("wrap_pc", 32'(pc), 32'h00);
      check("wrap_addr", 32'(instrAddr), 32'h00);
      check("wrap_rd", 32'(instrRd), 32'd1);

      // ---------------- reset mid-fetch ----------------
      do_reset();
      mem[0] = 8'h11;
      run_model(8'h00, 1);
      model_on = 1'b1;
      enable = 1'b1;
      wait_drain(100);
      begin
         int n;
         n = 0;
         while (!(instrRd && pc == 8'h01) && n < 20) begin
            @(negedge clock);
            n++;
         end
         check("mf_reach_fetch", 32'(n < 20), 32'd1);
      end
      model_on = 1'b0;
      @(negedge clock);
      #2 reset_n = 1'b0;
      #1;
      check("mf_rd_async", 32'(instrRd), 32'd0);
      check("mf_pc_async", 32'(pc), 32'h00);
      check("mf_addr_async", 32'(instrAddr), 32'h00);
      force_valid = 1'b1;
      enable = 1'b0;
      repeat (2) @(negedge clock);
      reset_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         check("mf_late_rd", 32'(instrRd), 32'd0);
         check("mf_late_ready", 32'(instrReady), 32'd0);
         check("mf_late_pc", 32'(pc), 32'h00);
         check("mf_late_opcode", 32'(opcode), 32'h0);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
